mlp_div_seq_31s_18s: RTL
========================

Name: mlp_div_seq_31s_18s

Overview:
- Iterative signed divider; the inverse of the 18x18 -> 31-bit signed multiply stage in the MLP datapath.
- Takes a 31-bit signed dividend (accumulated product) and an 18-bit signed divisor (scale/normaliser).
- Returns the quotient and remainder with C truncation semantics.
- Restoring, radix-2, one quotient bit per cycle, with valid/ready handshakes on both sides and an HLS-style ce stall.

Parameters:
- DIVIDEND_W, 31, dividend and quotient width (signed).
- DIVISOR_W, 18, divisor and remainder width (signed).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; 0 freezes all state
- in_valid  in  1  dividend/divisor valid
- in_ready  out  1  block can accept an operand pair
- dividend  in  DIVIDEND_W  signed dividend
- divisor  in  DIVISOR_W  signed divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  DIVIDEND_W  signed quotient
- remainder  out  DIVISOR_W  signed remainder
- div0  out  1  divisor was zero for this result

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- On reset: state=IDLE; in_ready=0 while reset is asserted, then 1 from the first clk edge after release; out_valid=0; quotient=0; remainder=0; div0=0; iteration counter=0.
- All state updates require ce=1. With ce=0 nothing changes: handshakes are not taken and outputs hold.

State machine (IDLE, CALC, DONE):
- IDLE: in_ready=1. On an edge with in_valid & ce:
  - latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend);
  - load |dividend| (DIVIDEND_W unsigned) and |divisor| (DIVISOR_W unsigned; -2^17 -> 2^17 exactly);
  - clear partial remainder (DIVISOR_W+1 bits) and counter; go to CALC.
  - If divisor==0, skip CALC and go directly to DONE with the div0 result.
- CALC: in_ready=0. Each ce edge:
  - shift {partial remainder, dividend register} left by 1;
  - trial-subtract |divisor|; if non-negative, keep the difference and shift in quotient bit 1, else shift in 0;
  - counter++.
  - After DIVIDEND_W iterations, sign-correct and register quotient/remainder/div0=0 on the same edge; go to DONE.
- DONE: out_valid=1; outputs stable.
  - On an edge with out_ready & ce: out_valid=0, go to IDLE.
  - Outputs keep their last value after the handshake.
- Latency: out_valid rises exactly DIVIDEND_W ce-cycles (31 by default) after the accept edge. Divide-by-zero latency is 1 cycle.
- Throughput: one operation per DIVIDEND_W+2 cycles. in_ready is low in CALC and DONE; there is no overlap.
- Arithmetic:
  - quotient truncates toward zero;
  - remainder carries the sign of the dividend;
  - |remainder| < |divisor|;
  - dividend = quotient*divisor + remainder whenever divisor != 0 and no overflow occurs.
- Overflow: -2^30 / -1 gives true result 2^30, which is not representable. quotient wraps to -2^30 (0x4000_0000 pattern) and remainder=0.
- Divide by zero: div0=1, quotient = all ones (-1), remainder = dividend[DIVISOR_W-1:0].
- Backpressure: out_ready held low keeps DONE indefinitely; in_ready stays 0.
- Reset mid-CALC or mid-DONE aborts the operation. The result is discarded and out_valid falls immediately (asynchronously).
- in_valid while in_ready=0 is ignored; the producer must hold its operands until the handshake.

Optional Feature:
- Macro: MLP_DIV_SAT_EN.
- Defined: divide-by-zero quotient saturates to 2^(DIVIDEND_W-1)-1 if dividend>=0, else -2^(DIVIDEND_W-1). The -2^30 / -1 overflow saturates to 2^30-1. remainder=0 in both cases. div0 behaves the same as without the macro.
- Undefined: wrap/all-ones behaviour as specified in Behaviour; no saturation logic is instantiated.

Test Plan:
- Basic: dividend=1000, divisor=7, out_ready=1 -> quotient=142, remainder=6, div0=0; out_valid exactly 31 cycles after accept.
- Signs: -1000/7 -> q=-142, r=-6; 1000/-7 -> q=-142, r=6; -1000/-7 -> q=142, r=-6.
- Extremes: -2^30 / -2^17 -> q=8192, r=0. (2^30-1) / (2^17-1) -> q=8192, r=8191.
- Divide by zero: 12345/0 -> div0=1, out_valid 1 cycle after accept; q=-1, r=12345. With MLP_DIV_SAT_EN: q=2^30-1, r=0.
- Overflow: -2^30 / -1 -> q=-2^30. With MLP_DIV_SAT_EN: q=2^30-1.
- Control: toggle ce low for 5 cycles mid-CALC -> latency extends by exactly 5. Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0. Assert reset at iteration 15 -> out_valid=0 and in_ready=0 during reset, in_ready=1 after release; the next op 20/3 gives q=6, r=2.

Source files
------------

// File: rtl/mlp_div_seq_31s_18s.sv
// -----------------------------------------------------------------------------
// mlp_div_seq_31s_18s
//
// Iterative signed divider for the MLP datapath: the inverse of the
// 18x18 -> 31-bit signed multiply stage. Restoring, radix-2 algorithm that
// retires one quotient bit per enabled clock. Results follow C truncation
// semantics: the quotient rounds toward zero and the remainder takes the
// sign of the dividend.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   ce         clock enable; 0 freezes every register
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair (IDLE only)
//   dividend   signed dividend, DIVIDEND_W bits
//   divisor    signed divisor, DIVISOR_W bits
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   quotient   signed quotient, DIVIDEND_W bits
//   remainder  signed remainder, DIVISOR_W bits
//   div0       divisor was zero for this result
//
// Optional build macro MLP_DIV_SAT_EN:
//   defined   - divide-by-zero and the single overflow case (-2^(W-1) / -1)
//               saturate the quotient and force the remainder to zero.
//   undefined - divide-by-zero returns quotient all ones and the low
//               DIVISOR_W bits of the dividend as remainder; overflow wraps.
// -----------------------------------------------------------------------------
module mlp_div_seq_31s_18s #(
    parameter int DIVIDEND_W = 31,
    parameter int DIVISOR_W  = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic signed [DIVISOR_W-1:0]  divisor,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DIVIDEND_W-1:0] quotient,
    output logic signed [DIVISOR_W-1:0]  remainder,
    output logic                         div0
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

`ifdef MLP_DIV_SAT_EN
    localparam logic [DIVIDEND_W-1:0] Q_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};
`endif

    // Two's-complement negate when neg is set. Used both for taking operand
    // magnitudes and for restoring result signs; the magnitude of the most
    // negative value maps onto its own bit pattern, which read unsigned is
    // exactly 2^(W-1).
    function automatic logic [DIVIDEND_W-1:0] cond_neg_q(
        input logic                  neg,
        input logic [DIVIDEND_W-1:0] v
    );
        return neg ? (~v + DIVIDEND_W'(1)) : v;
    endfunction

    function automatic logic [DIVISOR_W-1:0] cond_neg_r(
        input logic                 neg,
        input logic [DIVISOR_W-1:0] v
    );
        return neg ? (~v + DIVISOR_W'(1)) : v;
    endfunction

`ifdef MLP_DIV_SAT_EN
    // Divide-by-zero saturates toward the sign of the dividend.
    function automatic logic [DIVIDEND_W-1:0] sat_div0_q(input logic neg_dvd);
        return neg_dvd ? Q_MIN : Q_MAX;
    endfunction
`endif

    // Control / result registers (reset)
    logic [1:0]            state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  rdy_q,    rdy_d;
    logic                  vld_q,    vld_d;
    logic [DIVIDEND_W-1:0] quo_q,    quo_d;
    logic [DIVISOR_W-1:0]  remo_q,   remo_d;
    logic                  div0_q,   div0_d;

    // Iteration datapath registers (no reset; always reloaded on accept)
    logic [DIVIDEND_W-1:0] dvd_q,     dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q,     dvs_d;
    logic [DIVISOR_W:0]    prem_q,    prem_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;

    // One restoring step
    logic [DIVISOR_W:0]    prem_sh;
    logic [DIVISOR_W:0]    prem_trial;
    logic                  qbit;
    logic [DIVISOR_W:0]    prem_nx;
    logic [DIVIDEND_W-1:0] dvd_nx;

    // Sign-corrected final values
    logic [DIVIDEND_W-1:0] quo_fin;
    logic [DIVISOR_W-1:0]  rem_fin;

    // Accept-time values
    logic                  accept;
    logic [DIVIDEND_W-1:0] dvd_abs;
    logic [DIVISOR_W-1:0]  dvs_abs;
    logic [DIVIDEND_W-1:0] div0_quo;
    logic [DIVISOR_W-1:0]  div0_rem;

    assign accept  = in_valid && rdy_q;
    assign dvd_abs = cond_neg_q(dividend[DIVIDEND_W-1], dividend);
    assign dvs_abs = cond_neg_r(divisor[DIVISOR_W-1], divisor);

`ifdef MLP_DIV_SAT_EN
    assign div0_quo = sat_div0_q(dividend[DIVIDEND_W-1]);
    assign div0_rem = '0;
`else
    assign div0_quo = '1;
    assign div0_rem = dividend[DIVISOR_W-1:0];
`endif

    // Partial remainder never exceeds |divisor|-1 <= 2^(DIVISOR_W-1)-1, so
    // after the shift it still fits DIVISOR_W+1 bits.
    assign prem_sh    = {prem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
    assign prem_trial = prem_sh - {1'b0, dvs_q};
    assign qbit       = (prem_sh >= {1'b0, dvs_q});
    assign prem_nx    = qbit ? prem_trial : prem_sh;
    assign dvd_nx     = {dvd_q[DIVIDEND_W-2:0], qbit};

`ifdef MLP_DIV_SAT_EN
    // Only a positive result can overflow: magnitude 2^(W-1) with a
    // non-negative sign (-2^(W-1) / -1).
    logic ovf;
    assign ovf     = !neg_quo_q && dvd_nx[DIVIDEND_W-1];
    assign quo_fin = ovf ? Q_MAX : cond_neg_q(neg_quo_q, dvd_nx);
    assign rem_fin = ovf ? '0 : cond_neg_r(neg_rem_q, prem_nx[DIVISOR_W-1:0]);
`else
    assign quo_fin = cond_neg_q(neg_quo_q, dvd_nx);
    assign rem_fin = cond_neg_r(neg_rem_q, prem_nx[DIVISOR_W-1:0]);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vld_d     = vld_q;
        quo_d     = quo_q;
        remo_d    = remo_q;
        div0_d    = div0_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    neg_quo_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                    neg_rem_d = dividend[DIVIDEND_W-1];
                    dvd_d     = dvd_abs;
                    dvs_d     = dvs_abs;
                    prem_d    = '0;
                    cnt_d     = '0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        vld_d   = 1'b1;
                        div0_d  = 1'b1;
                        quo_d   = div0_quo;
                        remo_d  = div0_rem;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                dvd_d  = dvd_nx;
                prem_d = prem_nx;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                    vld_d   = 1'b1;
                    div0_d  = 1'b0;
                    quo_d   = quo_fin;
                    remo_d  = rem_fin;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase

        // in_ready is registered so it stays low during reset and rises on
        // the first enabled edge after release.
        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
            div0_q  <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            div0_q  <= div0_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign quotient  = quo_q;
    assign remainder = remo_q;
    assign div0      = div0_q;

endmodule
